calc_rr_sched: RTL and testbench
================================

// Module: calc_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one combinational calc unit (a, b, op -> res) between three
//  requester lanes, replacing three calc instances. Accepts operand sets via valid/ready,
//  drives the shared calc from latched operands and writes results to one register per lane.
//  Sits between the operand input registers and the result register stage of the exam datapath.
// PARAMETERS
//  W     3   operand/result width
//  OPW   2   opcode width (matches calc op field)
//  CNTW  8   width of completed-operation counter
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   3        lane i has operands pending
//  req_ready  out  3        lane i operands accepted this cycle (one-hot or zero)
//  req_a      in   3*W      lane i operand a at [i*W +: W]
//  req_b      in   3*W      lane i operand b at [i*W +: W]
//  req_op     in   3*OPW    lane i opcode at [i*OPW +: OPW]
//  calc_a     out  W        operand a to shared calc
//  calc_b     out  W        operand b to shared calc
//  calc_op    out  OPW      opcode to shared calc
//  calc_res   in   W        combinational result from shared calc
//  res_q      out  3*W      last result of lane i at [i*W +: W], held until overwritten
//  res_vld    out  3        one-cycle pulse: res_q lane i updated
//  busy       out  1        high in state EXEC
//  op_cnt     out  CNTW     completed operations, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last_grant=2 (lane 0 has first priority), operand latches=0,
//   res_q=0, res_vld=0, op_cnt=0, busy=0. Outputs are zero while rst_n=0.
//  FSM, two states:
//   IDLE: if any req_valid, grant = first valid lane in order last_grant+1, +2, +3 (mod 3);
//     req_ready[grant]=1 combinationally this cycle; at the edge latch that lane's a/b/op and
//     its index, set last_grant=grant, go EXEC. If no valid lane, stay IDLE; req_ready=0.
//   EXEC: calc_a/b/op = latched values; req_ready=0; at the edge res_q[lane]<=calc_res,
//     res_vld[lane]<=1 (one cycle), op_cnt<=op_cnt+1; go IDLE.
//  In IDLE calc_a/b/op = 0. Other lanes' res_q are never touched.
//  Latency: accepted at edge t (ready&valid) -> res_vld high during cycle t+2. Throughput: one
//   operation per 2 cycles; with all lanes valid the grant order is 0,1,2,0,... .
//  Handshake: a requester keeps req_valid and operands stable until req_ready; the scheduler never
//   asserts req_ready for a lane without req_valid. Dropping req_valid before grant is permitted and
//   just removes the lane from arbitration. Operands changing after accept do not affect the result.
//  Fairness: a continuously valid lane is granted within 3 grants (worst-case wait 6 cycles).
//  res_vld of one operation may coincide with the IDLE cycle granting the next; both allowed.
//  op_cnt wraps from 2^CNTW-1 to 0 without stalling.
//  Reset asserted in EXEC aborts the operation: no res_vld, no res_q write, no count.
//  Widths: calc_res used as-is (W bits); overflow is the calc's responsibility.
// TESTING
//  1 Reset then idle: no req_valid for 10 cycles -> req_ready=0, busy=0, res_q=0, op_cnt=0.
//  2 Single op: lane1 a=3,b=2,op=0 (add, calc returns 5) -> req_ready[1] at t, res_q[1]=5 and
//    res_vld=3'b010 in t+2, op_cnt=1.
//  3 Contention: all three valid from reset, held -> grants 0,1,2,0 at cycles 0,2,4,6; each
//    res_vld pulse exactly one cycle, op_cnt=4 after cycle 8.
//  4 Priority rotation: after lane2 granted, lanes 0 and 2 both valid -> lane0 granted next;
//    then lanes 1 and 2 valid -> lane1 granted.
//  5 Stable-after-accept: change lane0 operands in the EXEC cycle -> res_q[0] reflects the
//    accepted values only.
//  6 Reset mid-op: rst_n low during EXEC -> res_vld stays 0, res_q=0, op_cnt=0, state IDLE,
//    lane 0 first priority after release; plus op_cnt wrap from 255 -> 0 with CNTW=8.

Source files
------------

// File: rtl/calc_rr_sched_if.sv
// Bundle between three operand requesters, the shared combinational calc unit and the
// per-lane result stage of calc_rr_sched.
interface calc_rr_sched_if #(
  parameter int W    = 3,
  parameter int OPW  = 2,
  parameter int CNTW = 8
);
  // Handshake: lane i transfers on a cycle where req_valid[i] && req_ready[i]; the requester
  // holds req_valid and its operands stable until that cycle, and ready never rises without valid.
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [3*W-1:0]   req_a;
  logic [3*W-1:0]   req_b;
  logic [3*OPW-1:0] req_op;
  logic [W-1:0]     calc_a;
  logic [W-1:0]     calc_b;
  logic [OPW-1:0]   calc_op;
  logic [W-1:0]     calc_res;
  logic [3*W-1:0]   res_q;
  logic [2:0]       res_vld;
  logic             busy;
  logic [CNTW-1:0]  op_cnt;

  modport master (
    output req_valid, req_a, req_b, req_op, calc_res,
    input  req_ready, calc_a, calc_b, calc_op, res_q, res_vld, busy, op_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, calc_res,
    output req_ready, calc_a, calc_b, calc_op, res_q, res_vld, busy, op_cnt
  );
endinterface

// File: rtl/calc_rr_sched.sv
// Round-robin scheduler time-sharing one combinational calc unit between three lanes:
// accept one lane's operands in IDLE, drive the calc from latches in EXEC, store the result.
module calc_rr_sched #(
  parameter int W    = 3,
  parameter int OPW  = 2,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_rr_sched_if.slave    bus,
  output logic              state_o
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t          state_q;
  logic [1:0]      last_grant_q;
  logic [1:0]      lane_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [OPW-1:0]  op_q;
  logic [3*W-1:0]  res_q;
  logic [2:0]      res_vld_q;
  logic [CNTW-1:0] op_cnt_q;
  logic            busy_q;

  logic [1:0]      cand;
  logic [1:0]      grant;
  logic            grant_vld;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [OPW-1:0]  sel_op;

  // Scan lanes starting just after the last grant; the first valid one wins.
  always_comb begin
    cand      = last_grant_q;
    grant     = 2'd0;
    grant_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant == 2'(i)) begin
        sel_a  = bus.req_a[i*W +: W];
        sel_b  = bus.req_b[i*W +: W];
        sel_op = bus.req_op[i*OPW +: OPW];
      end
    end
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    bus.req_ready = 3'b000;
    if (rst_n && (state_q == IDLE) && grant_vld) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd2;
      lane_q       <= 2'd0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      res_vld_q    <= 3'b000;
      op_cnt_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      res_vld_q <= 3'b000;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q          <= sel_a;
            b_q          <= sel_b;
            op_q         <= sel_op;
            lane_q       <= grant;
            last_grant_q <= grant;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          for (int i = 0; i < 3; i++) begin
            if (lane_q == 2'(i)) begin
              res_q[i*W +: W] <= bus.calc_res;
              res_vld_q[i]    <= 1'b1;
            end
          end
          op_cnt_q <= op_cnt_q + CNTW'(1);
          // Clearing the latches makes the calc inputs read zero throughout IDLE.
          a_q      <= '0;
          b_q      <= '0;
          op_q     <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.calc_a  = a_q;
  assign bus.calc_b  = b_q;
  assign bus.calc_op = op_q;
  assign bus.res_q   = res_q;
  assign bus.res_vld = res_vld_q;
  assign bus.busy    = busy_q;
  assign bus.op_cnt  = op_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_calc_rr_sched.sv
// Directed bench for calc_rr_sched: vector table of single grants plus hand-written
// sequences for contention, operand stability, reset during EXEC and counter wrap.
module tb_calc_rr_sched;
  localparam int W    = 3;
  localparam int OPW  = 2;
  localparam int CNTW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  calc_rr_sched_if #(.W(W), .OPW(OPW), .CNTW(CNTW)) bus ();
  logic state_dbg;

  calc_rr_sched #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Shared calc: 0 add, 1 sub, 2 and, 3 xor, all modulo 2^W.
  function automatic logic [W-1:0] calc_model(logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb bus.calc_res = calc_model(bus.calc_a, bus.calc_b, bus.calc_op);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];

  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    int           ln;
    if (rst_n) begin
      if (bus.res_vld !== 3'b000) begin
        if (exp_q.size() == 0) begin
          check("res_vld_unexpected", 32'(bus.res_vld), 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ln = int'(e[W+1:W]);
          check("sb_res_vld", 32'(bus.res_vld), 32'(3'b001 << ln));
          check("sb_res_q", 32'(bus.res_q[ln*W +: W]), 32'(e[W-1:0]));
        end
      end
      if (bus.req_ready !== 3'b000) begin
        check("ready_onehot_valid",
              32'(($countones(bus.req_ready) == 1) && ((bus.req_ready & ~bus.req_valid) == 3'b000)),
              32'd1);
        for (int i = 0; i < 3; i++) begin
          if (bus.req_ready[i] && bus.req_valid[i]) begin
            exp_q.push_back({2'(i), calc_model(bus.req_a[i*W +: W], bus.req_b[i*W +: W],
                                               bus.req_op[i*OPW +: OPW])});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] exp_res[3];
  int           exp_cnt;

  task automatic set_lane(int i, logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
    bus.req_a[i*W +: W]      = a;
    bus.req_b[i*W +: W]      = b;
    bus.req_op[i*OPW +: OPW] = op;
  endtask

  task automatic junk_lane(int i);
    set_lane(i, W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), OPW'($urandom_range(0, 3)));
  endtask

  task automatic do_reset();
    bus.req_valid = 3'b000;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_res[i] = '0;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]     valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic [1:0]     grant;
    logic [W-1:0]   res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vec_t         v;
    logic [2:0]   order[4];
    logic [3*W-1:0] exp_all;

    vecs[0] = '{3'b010, 3'd3, 3'd2, 2'd0, 2'd1, 3'd5};  // single op, lane1 3+2
    vecs[1] = '{3'b111, 3'd6, 3'd3, 2'd1, 2'd2, 3'd3};  // after lane1 -> lane2, 6-3
    vecs[2] = '{3'b101, 3'd7, 3'd1, 2'd0, 2'd0, 3'd0};  // after lane2, {0,2} -> lane0, 7+1 wraps
    vecs[3] = '{3'b110, 3'd5, 3'd6, 2'd2, 2'd1, 3'd4};  // {1,2} -> lane1, 101&110
    vecs[4] = '{3'b001, 3'd5, 3'd3, 2'd3, 2'd0, 3'd6};  // lane0, 101^011
    vecs[5] = '{3'b100, 3'd2, 3'd7, 2'd1, 2'd2, 3'd3};  // lane2, 2-7 mod 8
    vecs[6] = '{3'b011, 3'd4, 3'd4, 2'd0, 2'd0, 3'd0};  // after lane2, {0,1} -> lane0
    vecs[7] = '{3'b111, 3'd1, 3'd2, 2'd3, 2'd1, 3'd3};  // after lane0, all -> lane1

    bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;

    // 1: reset then idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_res_q", 32'(bus.res_q), 32'd0);
    check("idle_op_cnt", 32'(bus.op_cnt), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
    check("idle_calc_a", 32'(bus.calc_a), 32'd0);

    // 2 + 4: table of grants with rotating priority
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      for (int l = 0; l < 3; l++) begin
        if (l == int'(v.grant)) set_lane(l, v.a, v.b, v.op);
        else junk_lane(l);
      end
      bus.req_valid = v.valid;
      #1;
      check("vec_ready", 32'(bus.req_ready), 32'(3'b001 << v.grant));
      @(posedge clk);
      #1;
      bus.req_valid = 3'b000;
      for (int l = 0; l < 3; l++) junk_lane(l);
      check("vec_busy", 32'(bus.busy), 32'd1);
      check("vec_exec_ready", 32'(bus.req_ready), 32'd0);
      check("vec_calc_in", 32'({bus.calc_a, bus.calc_b, bus.calc_op}), 32'({v.a, v.b, v.op}));
      @(posedge clk);
      #1;
      exp_res[v.grant] = v.res;
      exp_cnt++;
      exp_all = {exp_res[2], exp_res[1], exp_res[0]};
      check("vec_res_vld", 32'(bus.res_vld), 32'(3'b001 << v.grant));
      check("vec_res_q", 32'(bus.res_q), 32'(exp_all));
      check("vec_op_cnt", 32'(bus.op_cnt), 32'(exp_cnt));
      check("vec_busy_idle", 32'(bus.busy), 32'd0);
    end

    // 5: operands changed during EXEC must not leak into the result
    set_lane(0, 3'd2, 3'd3, 2'd0);
    bus.req_valid = 3'b001;
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    set_lane(0, 3'd7, 3'd7, 2'd1);
    check("stable_calc_a", 32'(bus.calc_a), 32'd2);
    @(posedge clk);
    #1;
    check("stable_res_q0", 32'(bus.res_q[0 +: W]), 32'd5);
    check("stable_res_q12", 32'(bus.res_q[W +: 2*W]), 32'({exp_res[2], exp_res[1]}));
    @(posedge clk);
    #1;

    // 3: contention from reset, grants 0,1,2,0
    do_reset();
    set_lane(0, 3'd1, 3'd1, 2'd0);
    set_lane(1, 3'd4, 3'd1, 2'd1);
    set_lane(2, 3'd6, 3'd3, 2'd3);
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    bus.req_valid = 3'b111;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c % 2 == 0) begin
        check("cont_grant", 32'(bus.req_ready), 32'(order[c/2]));
      end else begin
        check("cont_exec_ready", 32'(bus.req_ready), 32'd0);
        check("cont_busy", 32'(bus.busy), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 3'b000;
    check("cont_op_cnt", 32'(bus.op_cnt), 32'd4);
    check("cont_res_q", 32'(bus.res_q), 32'({3'd5, 3'd3, 3'd2}));
    @(posedge clk);
    #1;
    check("cont_pulse_end", 32'(bus.res_vld), 32'd0);

    // 6: reset during EXEC aborts the operation
    set_lane(1, 3'd2, 3'd2, 2'd0);
    bus.req_valid = 3'b010;
    @(posedge clk);
    #1;
    check("abort_in_exec", 32'(state_dbg), 32'd1);
    bus.req_valid = 3'b111;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_res_q", 32'(bus.res_q), 32'd0);
    check("abort_op_cnt", 32'(bus.op_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("abort_res_vld", 32'(bus.res_vld), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("abort_first_prio", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    @(posedge clk);
    #1;
    check("abort_next_vld", 32'(bus.res_vld), 32'd1);
    check("abort_next_cnt", 32'(bus.op_cnt), 32'd1);

    // 6: op_cnt wrap 255 -> 0
    do_reset();
    set_lane(0, 3'd1, 3'd2, 2'd0);
    bus.req_valid = 3'b001;
    repeat (510) @(posedge clk);
    #1;
    check("wrap_255", 32'(bus.op_cnt), 32'd255);
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    check("wrap_0", 32'(bus.op_cnt), 32'd0);
    check("wrap_res_q0", 32'(bus.res_q[0 +: W]), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
